// File: rtl/dual_ram_sync_rd_if.sv
// Read/write port bundle for dual_ram_sync_rd.
// master drives requests, slave returns read data and status.
interface dual_ram_sync_rd_if #(
    parameter int DW = 8,
    parameter int LW = 8,
    parameter int AW = 4
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [DW/LW-1:0] wr_be;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be,
        output rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be,
        input  rd_en, rd_addr,
        output rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/dual_ram_sync_rd.sv
// Simple dual-port RAM, byte-lane writes, registered write-first read.
// DUAL_RAM_SYNC_RD_OUTREG_EN adds a second output stage (latency 2).
module dual_ram_sync_rd #(
    parameter int DW    = 8,
    parameter int LW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    dual_ram_sync_rd_if.slave bus
);
    localparam int NL   = DW / LW;
    localparam bit FULL = (DEPTH == (2 ** AW));

    logic [DW-1:0] mem [DEPTH];

    logic          wr_in;
    logic          rd_in;
    logic          wr_ok;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] s1_data;
    logic          s1_valid;
    logic          err_q;

    // A full address space cannot be exceeded, so skip the compare.
    if (FULL) begin : g_full
        assign wr_in = 1'b1;
        assign rd_in = 1'b1;
    end else begin : g_part
        localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
        assign wr_in = ({1'b0, bus.wr_addr} < DEPTH_C);
        assign rd_in = ({1'b0, bus.rd_addr} < DEPTH_C);
    end

    assign wr_ok = bus.wr_en && wr_in;

    // Array update, lane by lane; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.wr_be[i])
                    mem[bus.wr_addr][i*LW +: LW] <= bus.wr_data[i*LW +: LW];
            end
        end
    end

    // Read word with write-first forwarding of enabled lanes.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[bus.rd_addr];
            if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
                for (int i = 0; i < NL; i++) begin
                    if (bus.wr_be[i])
                        rd_word[i*LW +: LW] = bus.wr_data[i*LW +: LW];
                end
            end
        end
    end

    // First read stage plus sticky range error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_valid <= bus.rd_en;
            if (bus.rd_en)
                s1_data <= rd_word;
            if ((bus.wr_en && !wr_in) || (bus.rd_en && !rd_in))
                err_q <= 1'b1;
        end
    end

`ifdef DUAL_RAM_SYNC_RD_OUTREG_EN
    logic [DW-1:0] s2_data;
    logic          s2_valid;

    // Second output stage; loads only behind a valid first stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_data <= s1_data;
        end
    end

    assign bus.rd_data  = s2_data;
    assign bus.rd_valid = s2_valid;
`else
    assign bus.rd_data  = s1_data;
    assign bus.rd_valid = s1_valid;
`endif

    assign bus.rd_err = err_q;
endmodule
